done_collector: RTL
===================

Name: done_collector

Overview:
- Parametrised successor to the fixed 4-input done generator in the neural-network datapath.
- Collects per-neuron/per-layer completion flags over a "round" opened by start.
- Latches each flag (sticky) so channels may finish on different cycles; honours a per-round participation mask.
- Emits a one-cycle done pulse when every masked channel has reported, or a timeout pulse with the missing-channel set if they have not.

Parameters:
- N_CH, 4, number of done channels.
- TIMEOUT, 200, max COLLECT cycles before timeout (>=2).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT-1.
- RND_W, 16, width of the completed-round counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  opens a new round; a 1-cycle pulse is expected, a level is treated as repeated restarts.
- ch_mask  input  N_CH  participating channels, sampled only on start.
- ch_done  input  N_CH  per-channel completion flag, pulse or level.
- busy  output  1  high while a round is collecting.
- done  output  1  1-cycle pulse: all masked channels reported.
- timeout  output  1  1-cycle pulse: round expired incomplete.
- pending  output  N_CH  masked channels not yet reported.
- rounds  output  RND_W  count of successfully completed rounds, wraps.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, timeout=0, pending=0, rounds=0; internal mask_q=0, seen=0, cnt=0.
- All outputs are registered.
- States: IDLE, COLLECT.
- IDLE:
  - On start with ch_mask!=0: mask_q<=ch_mask, seen<=0, cnt<=0, pending<=ch_mask, busy<=1, go COLLECT.
  - On start with ch_mask==0: no COLLECT; done pulses the next cycle, rounds increments, busy stays 0, pending<=0.
- COLLECT, each edge with no start:
  - hit = ch_done & mask_q; nseen = seen | hit.
  - If nseen==mask_q: done<=1 for one cycle, busy<=0, pending<=0, rounds<=rounds+1, go IDLE. done is visible the cycle after the edge that sampled the last required flag.
  - Else if cnt==TIMEOUT-1: timeout<=1 for one cycle, busy<=0, pending<=mask_q & ~nseen, go IDLE.
  - Else: seen<=nseen, pending<=mask_q & ~nseen, cnt<=cnt+1.
- Completion and timeout on the same edge: completion wins; no timeout pulse.
- ch_done bits outside mask_q are ignored in every state.
- ch_done sampled on the same edge as start is not credited; channels must report after the round opens.
- A channel reporting more than once, or holding its flag as a level, is harmless (sticky OR).
- start during COLLECT: abort and restart. Recapture mask, seen<=0, cnt<=0; no done or timeout pulse; rounds unchanged.
- pending after timeout holds the missing set through IDLE until the next start or reset. pending after done is 0.
- done and timeout are never high together; each is high for exactly one cycle per event.
- rounds wraps from 2^RND_W-1 to 0.
- Reset mid-round: immediately IDLE with no pulse; the round is lost.

Test Plan:
- N_CH=4: start with ch_mask=4'b1111, then ch_done=0001, 0010, 0000, 1100 on successive cycles -> pending 1110, 1100, 1100, 0000; done high exactly 1 cycle after the 1100 edge; busy falls same edge; rounds=1.
- ch_mask=4'b1011, ch_done=1011 in the first COLLECT cycle -> done next cycle. Repeat with ch_done=0100 only -> never done, timeout after TIMEOUT cycles.
- TIMEOUT=8, ch_mask=1111, only ch_done=0101 arrives -> timeout pulse at cycle 8 of COLLECT; pending=1010 held in IDLE; done=0; rounds unchanged.
- Last required ch_done arrives on the final timeout cycle (cnt=TIMEOUT-1) -> done=1, timeout=0.
- start with ch_mask=0 -> done pulse next cycle, busy=0. Then start mid-COLLECT after 0011 reported (mask 1111) -> pending returns to 1111 and no pulse; 1111 then completes normally.
- Deassert rst_n mid-COLLECT -> all outputs 0 asynchronously. Also preload rounds to 16'hFFFF and complete a round -> rounds=0.

Source files
------------

// File: rtl/done_collector.sv
// done_collector: gathers per-channel completion flags over a round opened by start.
//
// A round opens on start and captures ch_mask as the set of participating channels.
// Each masked channel's ch_done is latched (sticky), so channels may report on different
// cycles and may pulse or hold a level. When every masked channel has reported, a
// one-cycle done pulse is issued and the round counter advances. If the round is still
// incomplete after TIMEOUT collect cycles, a one-cycle timeout pulse is issued instead,
// and pending keeps the missing channels until the next start.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   opens a new round (a held level restarts on every cycle)
//   ch_mask  in   participating channels, sampled only with start
//   ch_done  in   per-channel completion flags
//   busy     out  a round is collecting
//   done     out  one-cycle pulse: all masked channels reported
//   timeout  out  one-cycle pulse: round expired incomplete
//   pending  out  masked channels not yet reported (missing set after a timeout)
//   rounds   out  count of successfully completed rounds, wraps
//
// All outputs are registered.

module done_collector #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RND_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [N_CH-1:0]  ch_done,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [N_CH-1:0]  pending,
  output logic [RND_W-1:0] rounds
);

  // Elaboration-time parameter sanity.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("done_collector: TIMEOUT must be at least 2");
  end
  if ((TIMEOUT - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("done_collector: CNT_W too narrow for TIMEOUT-1");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e state_q, state_d;

  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [RND_W-1:0] rounds_q, rounds_d;

  // Shared round-status terms.
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] nseen;
  logic            all_seen;
  logic            expired;
  logic            mask_empty;

  always_comb begin
    hit        = ch_done & mask_q;  // flags outside the round's mask never count
    nseen      = seen_q | hit;
    all_seen   = (nseen == mask_q);
    expired    = (cnt_q == CntLast);
    mask_empty = (ch_mask == '0);
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (start) begin
      // An empty mask completes at once, so it never enters the collect state.
      state_d = mask_empty ? StIdle : StCollect;
    end else if (state_q == StCollect) begin
      if (all_seen || expired) begin
        state_d = StIdle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_d    = mask_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    pending_d = pending_q;
    rounds_d  = rounds_q;

    if (start) begin
      // start wins over everything: a running round is abandoned without a pulse.
      // ch_done on this edge is deliberately not credited to the new round.
      mask_d = ch_mask;
      seen_d = '0;
      cnt_d  = '0;
      if (mask_empty) begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pending_d = '0;
        rounds_d  = rounds_q + RND_W'(1);
      end else begin
        busy_d    = 1'b1;
        pending_d = ch_mask;
      end
    end else if (state_q == StCollect) begin
      if (all_seen) begin
        // Completion takes priority over an expiry on the same edge.
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pending_d = '0;
        rounds_d  = rounds_q + RND_W'(1);
      end else if (expired) begin
        busy_d    = 1'b0;
        timeout_d = 1'b1;
        pending_d = mask_q & ~nseen;
      end else begin
        seen_d    = nseen;
        pending_d = mask_q & ~nseen;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      seen_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      pending_q <= '0;
      rounds_q  <= '0;
    end else begin
      mask_q    <= mask_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      pending_q <= pending_d;
      rounds_q  <= rounds_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign pending = pending_q;
  assign rounds  = rounds_q;

endmodule
